// File: rtl/midi_stream_decoder_pkg.sv
// -----------------------------------------------------------------------------
// midi_stream_decoder_pkg
// Shared types and constants for the MIDI byte-stream decoder:
//   - command encodings carried in status[6:4]
//   - named status bytes (SysEx framing, system common, realtime)
//   - parser state encoding
//   - decoded message record as stored in the output FIFO
// -----------------------------------------------------------------------------
package midi_stream_decoder_pkg;

  localparam int MIDI_CMD_SIZE = 2;

  typedef enum logic [MIDI_CMD_SIZE:0] {
    CMD_NOTE_OFF = 3'd0,
    CMD_NOTE_ON  = 3'd1,
    CMD_POLY_AT  = 3'd2,
    CMD_CC       = 3'd3,
    CMD_PROG     = 3'd4,
    CMD_CH_AT    = 3'd5,
    CMD_PITCH    = 3'd6,
    CMD_SYS      = 3'd7
  } midi_cmd_e;

  // System common
  localparam logic [7:0] ST_SYSEX_START = 8'hF0;
  localparam logic [7:0] ST_MTC_QFRAME  = 8'hF1;
  localparam logic [7:0] ST_SONG_POS    = 8'hF2;
  localparam logic [7:0] ST_SONG_SEL    = 8'hF3;
  localparam logic [7:0] ST_TUNE_REQ    = 8'hF6;
  localparam logic [7:0] ST_SYSEX_END   = 8'hF7;

  // Realtime
  localparam logic [7:0] ST_TIMING_CLK  = 8'hF8;
  localparam logic [7:0] ST_START       = 8'hFA;
  localparam logic [7:0] ST_CONT        = 8'hFB;
  localparam logic [7:0] ST_STOP        = 8'hFC;
  localparam logic [7:0] ST_ACT_SENSE   = 8'hFE;
  localparam logic [7:0] ST_SYS_RESET   = 8'hFF;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_DATA0 = 2'd1,
    PS_DATA1 = 2'd2,
    PS_SYSEX = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic [MIDI_CMD_SIZE:0] cmd;
    logic [3:0]             ch_sysn;
    logic [6:0]             data0;
    logic [6:0]             data1;
  } midi_msg_t;

  localparam int MSG_W = $bits(midi_msg_t);

  // Data bytes expected after a channel-voice status.
  function automatic logic [1:0] channel_need(input logic [2:0] cmd);
    return (cmd == CMD_PROG || cmd == CMD_CH_AT) ? 2'd1 : 2'd2;
  endfunction

  // F9 and FD are undefined realtime codes and are never forwarded.
  function automatic logic rt_defined(input logic [7:0] b);
    return (b != 8'hF9) && (b != 8'hFD);
  endfunction

  // The status byte always has bit 7 set, so only bits 6:0 are carried.
  function automatic midi_msg_t make_msg(input logic [6:0] st,
                                         input logic [6:0] d0,
                                         input logic [6:0] d1);
    midi_msg_t m;
    m.cmd     = st[6:4];
    m.ch_sysn = st[3:0];
    m.data0   = d0;
    m.data1   = d1;
    return m;
  endfunction

endpackage

// File: rtl/midi_fifo.sv
// -----------------------------------------------------------------------------
// midi_fifo
// Synchronous first-word-fall-through FIFO with a registered head.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push/i_data: write request and entry
//   i_pop        : read request, ignored while empty
//   o_data       : registered head entry; holds its value while empty
//   o_empty      : no entry available
//   o_overflow   : one-cycle pulse when a push was dropped (full, no pop)
// Pointers carry one extra MSB so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module midi_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_head;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [AW:0]      w_count;
  logic [AW-1:0]    w_rd_next_idx;

  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop         = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_push        = i_push && (!w_full || w_pop);
  assign w_drop        = i_push && w_full && !w_pop;
  assign w_count       = r_wr_ptr - r_rd_ptr;
  assign w_rd_next_idx = r_rd_ptr[AW-1:0] + AW'(1);

  // NOTE: storage has no reset; only the head register is ever visible, and
  // it is reset, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      // Head tracks mem[rd_ptr]: load the incoming entry when it becomes the
      // head, otherwise the next stored entry on a pop that leaves data behind.
      if (w_push && (w_empty || (w_pop && w_count == (AW+1)'(1))))
        r_head <= i_data;
      else if (w_pop && w_count != (AW+1)'(1))
        r_head <= r_mem[w_rd_next_idx];
    end
  end

  assign o_data     = r_head;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/midi_stream_decoder.sv
// -----------------------------------------------------------------------------
// midi_stream_decoder
// MIDI byte-stream parser with running status, realtime interleaving, SysEx
// skipping and per-channel filtering; decoded messages queue in a FWFT FIFO.
//   clk, reset          : clock, asynchronous active-low reset
//   dataInReady, dataIn : received-byte strobe and byte
//   midi_rdy, midi_ack  : FIFO head valid / consumer pop
//   midi_cmd            : status[6:4] (7 = system message)
//   midi_ch_sysn        : status[3:0], channel or system sub-code
//   midi_data0/1        : data bytes, 0 when unused
//   overflow            : pulse when a completed message found the FIFO full
// -----------------------------------------------------------------------------
module midi_stream_decoder
  import midi_stream_decoder_pkg::*;
#(
  parameter logic [15:0] CH_MASK       = 16'hFFFF,
  parameter int          FIFO_DEPTH    = 4,
  parameter bit          PASS_REALTIME = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dataInReady,
  input  logic [7:0]             dataIn,
  output logic                   midi_rdy,
  input  logic                   midi_ack,
  output logic [MIDI_CMD_SIZE:0] midi_cmd,
  output logic [3:0]             midi_ch_sysn,
  output logic [6:0]             midi_data0,
  output logic [6:0]             midi_data1,
  output logic                   overflow
);

  parse_state_e r_state;
  logic         r_rs_valid;   // running status usable for a new message
  logic [6:0]   r_status;     // status of the message being assembled
  logic [1:0]   r_need;
  logic [6:0]   r_d0;
  logic         r_push;
  midi_msg_t    r_push_msg;

  logic [6:0]   w_data;
  logic         w_data_taken;
  logic         w_complete;
  midi_msg_t    w_done_msg;
  midi_msg_t    w_head;
  logic         w_empty;

  // System messages bypass the channel mask.
  function automatic logic emit_ok(input logic [6:0] st);
    return (st[6:4] != CMD_SYS) ? CH_MASK[st[3:0]] : 1'b1;
  endfunction

  assign w_data = dataIn[6:0];

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_data_taken = 1'b0;
    w_complete   = 1'b0;
    w_done_msg   = '0;
    if (dataInReady && !dataIn[7]) begin
      // IDLE with running status acts as DATA0 of a repeated message.
      w_data_taken = (r_state == PS_DATA0) || (r_state == PS_IDLE && r_rs_valid);
      if (r_state == PS_DATA1) begin
        w_complete = 1'b1;
        w_done_msg = make_msg(r_status, r_d0, w_data);
      end else if (w_data_taken && r_need == 2'd1) begin
        w_complete = 1'b1;
        w_done_msg = make_msg(r_status, w_data, 7'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= PS_IDLE;
      r_rs_valid <= 1'b0;
      r_status   <= '0;
      r_need     <= '0;
      r_d0       <= '0;
      r_push     <= 1'b0;
      r_push_msg <= '0;
    end else begin
      r_push <= 1'b0;
      if (dataInReady) begin
        if (dataIn[7:3] == 5'b11111) begin
          // Realtime leaves all parser state untouched.
          if (PASS_REALTIME && rt_defined(dataIn)) begin
            r_push     <= 1'b1;
            r_push_msg <= make_msg(dataIn[6:0], 7'd0, 7'd0);
          end
        end else if (dataIn[7]) begin
          // Any non-realtime status also ends SysEx and aborts a partial message.
          r_status <= dataIn[6:0];
          if (dataIn[6:4] != CMD_SYS) begin
            r_rs_valid <= 1'b1;
            r_need     <= channel_need(dataIn[6:4]);
            r_state    <= PS_DATA0;
          end else begin
            r_rs_valid <= 1'b0;
            case (dataIn)
              ST_SYSEX_START: r_state <= PS_SYSEX;
              ST_MTC_QFRAME, ST_SONG_SEL: begin
                r_need  <= 2'd1;
                r_state <= PS_DATA0;
              end
              ST_SONG_POS: begin
                r_need  <= 2'd2;
                r_state <= PS_DATA0;
              end
              ST_TUNE_REQ: begin
                r_push     <= 1'b1;
                r_push_msg <= make_msg(dataIn[6:0], 7'd0, 7'd0);
                r_state    <= PS_IDLE;
              end
              default: r_state <= PS_IDLE;  // F4, F5, stray F7
            endcase
          end
        end else if (w_complete) begin
          r_state <= PS_IDLE;
          if (emit_ok(r_status)) begin
            r_push     <= 1'b1;
            r_push_msg <= w_done_msg;
          end
        end else if (w_data_taken) begin
          r_d0    <= w_data;
          r_state <= PS_DATA1;
        end
        // Data bytes in SYSEX, or in IDLE without running status, are dropped.
      end
    end
  end

  midi_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (r_push),
    .i_data     (r_push_msg),
    .i_pop      (midi_ack),
    .o_data     (w_head),
    .o_empty    (w_empty),
    .o_overflow (overflow)
  );

  assign midi_rdy     = !w_empty;
  assign midi_cmd     = w_head.cmd;
  assign midi_ch_sysn = w_head.ch_sysn;
  assign midi_data0   = w_head.data0;
  assign midi_data1   = w_head.data1;

endmodule
